// File: rtl/unit_input_rx.sv
// Input receiver: byte FIFO, packet parser (IDLE/DATA/DROP) and two
// double-buffered 32x32-bit word slots read by the core.
module unit_input_rx #(
    parameter int WORD_MAX_LEN = 64,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  in,
    input  logic        in_ctrl,
    input  logic        wr_en,
    output logic        afull,
    output logic        ready,
    output logic [4:0]  init_data,
    output logic        init_valid,
    output logic        slot_valid,
    output logic [6:0]  key_len,
    input  logic [4:0]  rd_addr,
    output logic [31:0] dout,
    input  logic        slot_release,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshakes: wr_en is a one-cycle push with no back-pressure (the sender
    // must honour afull/ready); slot_valid/slot_release is a level/strobe pair
    // where a release is only accepted while slot_valid is high.

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int AFULL_LVL = FIFO_DEPTH - AFULL_MARGIN;
    localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   AFULL_C  = AFULL_LVL[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    MAXLEN_C = WORD_MAX_LEN[7:0];

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP} state_t;

    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] fifo_wp, fifo_rp;
    logic [AW:0]   fifo_cnt, fifo_cnt_d;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]    head_byte;
    logic          head_ctrl;

    state_t      state, state_d;
    logic [6:0]  idx, idx_d;
    logic [23:0] pack, pack_d;
    logic [6:0]  klen, klen_d;
    logic [7:0]  klen_up, end_idx;
    logic        wr_word, commit, pkt_end, perr, init_fire;

    logic [31:0]     slot_mem [64];
    logic [1:0]      slot_full, slot_full_d;
    logic [1:0][6:0] slot_klen;
    logic            wr_ptr, rd_ptr, rel, hdr_write;
    logic            in_flight, in_flight_d;

    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_push  = wr_en && !fifo_full;
    assign {head_ctrl, head_byte} = fifo_mem[fifo_rp];

    always_comb begin
        fifo_cnt_d = fifo_cnt;
        if (fifo_push && !fifo_pop)
            fifo_cnt_d = fifo_cnt + CNT_ONE;
        else if (!fifo_push && fifo_pop)
            fifo_cnt_d = fifo_cnt - CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (fifo_push)
            fifo_mem[fifo_wp] <= {in_ctrl, in};
    end

    // Last byte index of a packet: 40 header/payload bytes plus key rounded up to words.
    assign klen_up = ({1'b0, klen} + 8'd3) & 8'hFC;
    assign end_idx = klen_up + 8'd39;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        pack_d    = pack;
        klen_d    = klen;
        fifo_pop  = 1'b0;
        wr_word   = 1'b0;
        commit    = 1'b0;
        pkt_end   = 1'b0;
        perr      = 1'b0;
        init_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_ctrl && head_byte == 8'h00) begin
                        // A data header waits at the FIFO head until a slot is free.
                        if (!slot_full[wr_ptr]) begin
                            fifo_pop = 1'b1;
                            state_d  = S_DATA;
                            idx_d    = 7'd1;
                            pack_d   = '0;
                        end
                    end else if (head_ctrl && head_byte[2:0] == 3'b001) begin
                        fifo_pop  = 1'b1;
                        init_fire = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        perr     = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_ctrl) begin
                        state_d = S_IDLE;
                        pkt_end = 1'b1;
                        if (idx > 7'd32 && {1'b0, idx} == end_idx) begin
                            wr_word = 1'b1;
                            commit  = 1'b1;
                        end else begin
                            perr = 1'b1;
                        end
                    end else if (idx == 7'd127) begin
                        perr    = 1'b1;
                        state_d = S_DROP;
                    end else if (idx == 7'd32 && (head_byte == 8'h00 || head_byte > MAXLEN_C)) begin
                        perr    = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        if (idx == 7'd32)
                            klen_d = head_byte[6:0];
                        case (idx[1:0])
                            2'd0:    pack_d[7:0]   = head_byte;
                            2'd1:    pack_d[15:8]  = head_byte;
                            2'd2:    pack_d[23:16] = head_byte;
                            default: wr_word       = 1'b1;
                        endcase
                        idx_d = idx + 7'd1;
                    end
                end
            end
            S_DROP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_ctrl) begin
                        state_d = S_IDLE;
                        pkt_end = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rel       = slot_release && slot_full[rd_ptr];
    assign hdr_write = fifo_push && in_ctrl && (in == 8'h00);

    always_comb begin
        slot_full_d = slot_full;
        if (commit)
            slot_full_d[wr_ptr] = 1'b1;
        if (rel)
            slot_full_d[rd_ptr] = 1'b0;
        in_flight_d = in_flight;
        if (hdr_write)
            in_flight_d = 1'b1;
        else if (pkt_end)
            in_flight_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (wr_word)
            slot_mem[{wr_ptr, idx[6:2]}] <= {head_byte, pack};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_cnt   <= '0;
            afull      <= 1'b0;
            state      <= S_IDLE;
            idx        <= '0;
            pack       <= '0;
            klen       <= '0;
            slot_full  <= '0;
            slot_klen  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_flight  <= 1'b0;
            ready      <= 1'b1;
            err        <= 1'b0;
            init_valid <= 1'b0;
            init_data  <= '0;
            dout       <= '0;
        end else begin
            if (fifo_push)
                fifo_wp <= fifo_wp + PTR_ONE;
            if (fifo_pop)
                fifo_rp <= fifo_rp + PTR_ONE;
            fifo_cnt   <= fifo_cnt_d;
            afull      <= (fifo_cnt_d >= AFULL_C);
            state      <= state_d;
            idx        <= idx_d;
            pack       <= pack_d;
            klen       <= klen_d;
            slot_full  <= slot_full_d;
            if (commit) begin
                slot_klen[wr_ptr] <= klen;
                wr_ptr            <= ~wr_ptr;
            end
            if (rel)
                rd_ptr <= ~rd_ptr;
            in_flight  <= in_flight_d;
            ready      <= !in_flight_d && (slot_full_d != 2'b11);
            err        <= err | perr | (wr_en & fifo_full);
            init_valid <= init_fire;
            if (init_fire)
                init_data <= head_byte[7:3];
            dout       <= slot_mem[{rd_ptr, rd_addr}];
        end
    end

    assign slot_valid = slot_full[rd_ptr];
    assign key_len    = slot_klen[rd_ptr];
    assign dbg_state  = state;

endmodule

// File: tb/tb_unit_input_rx.sv
// Randomized bench for unit_input_rx: packets are built from the framing rules
// and the expected slot words are queued in a scoreboard.
module tb_unit_input_rx;

    localparam int WML = 64;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  in;
    logic        in_ctrl, wr_en;
    logic        afull, ready;
    logic [4:0]  init_data;
    logic        init_valid, slot_valid;
    logic [6:0]  key_len;
    logic [4:0]  rd_addr;
    logic [31:0] dout;
    logic        slot_release, err;
    logic [1:0]  dbg_state;

    unit_input_rx #(.WORD_MAX_LEN(WML), .FIFO_DEPTH(16), .AFULL_MARGIN(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .in(in), .in_ctrl(in_ctrl), .wr_en(wr_en),
        .afull(afull), .ready(ready), .init_data(init_data), .init_valid(init_valid),
        .slot_valid(slot_valid), .key_len(key_len), .rd_addr(rd_addr), .dout(dout),
        .slot_release(slot_release), .err(err), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int init_cnt = 0;

    logic [31:0] exp_q[$];
    int          nw_q[$];
    int          klen_q[$];

    always @(negedge CLK) if (init_valid === 1'b1) init_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic c);
        in = b; in_ctrl = c; wr_en = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0; in_ctrl = 1'b0;
    endtask

    function automatic int end_of(input int k);
        return 39 + ((k + 3) / 4) * 4;
    endfunction

    // Sends one data packet; the model queues its words only if it should commit.
    task automatic send_packet(input int klen, input int last_idx, input bit zero_payload);
        logic [7:0] b [128];
        int last;
        last = (last_idx < 0) ? end_of(klen) : last_idx;
        for (int i = 0; i <= last; i++) begin
            if (i == 0) b[i] = 8'h00;
            else if (i == 32) b[i] = 8'(klen);
            else if (zero_payload) b[i] = 8'h00;
            else b[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i <= last; i++) begin
            write_byte(b[i], (i == 0) || (i == last));
            if (i == 0) check("ready_after_hdr", 32'(ready), 0);
        end
        if (klen >= 1 && klen <= WML && last == end_of(klen)) begin
            for (int w = 0; w < (last + 1) / 4; w++)
                exp_q.push_back({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
            nw_q.push_back((last + 1) / 4);
            klen_q.push_back(klen);
        end
    endtask

    task automatic wait_slot(input string tag);
        int n = 0;
        while (slot_valid !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
        check(tag, 32'(slot_valid), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
        check(tag, 32'(ready), 1);
    endtask

    task automatic read_slot(input string tag);
        int nw, k;
        check({tag, "_sb_nonempty"}, 32'(nw_q.size() != 0), 1);
        if (nw_q.size() == 0) return;
        nw = nw_q.pop_front();
        k  = klen_q.pop_front();
        check({tag, "_klen"}, 32'(key_len), 32'(k));
        for (int a = 0; a < nw; a++) begin
            rd_addr = 5'(a);
            @(negedge CLK);
            check($sformatf("%s_w%0d", tag, a), dout, exp_q.pop_front());
        end
    endtask

    task automatic release_slot();
        slot_release = 1'b1;
        @(negedge CLK);
        slot_release = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_afull"}, 32'(afull), 0);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_slot_valid"}, 32'(slot_valid), 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_key_len"}, 32'(key_len), 0);
        check({tag, "_init_data"}, 32'(init_data), 0);
        check({tag, "_init_valid"}, 32'(init_valid), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_vals(tag);
        RST_N = 1'b1;
        @(negedge CLK);
        exp_q.delete(); nw_q.delete(); klen_q.delete();
    endtask

    initial begin
        int c0, k, d;
        RST_N = 1'b0; in = '0; in_ctrl = 1'b0; wr_en = 1'b0; rd_addr = '0; slot_release = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_vals("por");
        RST_N = 1'b1;
        @(negedge CLK);

        // key_len=5 packet with zero payload: word 8 carries only the key length
        wait_ready("rdy_k5");
        send_packet(5, -1, 1);
        wait_slot("slot_k5");
        check("klen_k5", 32'(key_len), 5);
        check("ready_k5", 32'(ready), 1);
        rd_addr = 5'd8;
        @(negedge CLK);
        check("word8_k5", dout, 32'h0000_0005);
        read_slot("data_k5");
        release_slot();
        check("slot_free_k5", 32'(slot_valid), 0);

        // back-to-back init headers
        c0 = init_cnt;
        write_byte(8'h41, 1'b1);
        write_byte(8'h41, 1'b1);
        idle(4);
        check("init_pulses", 32'(init_cnt - c0), 2);
        check("init_data", 32'(init_data), 8);
        check("init_no_slot", 32'(slot_valid), 0);
        check("init_no_err", 32'(err), 0);

        // two packets without release, then release one
        send_packet($urandom_range(1, WML), -1, 0);
        wait_slot("slot_a");
        check("ready_one_free", 32'(ready), 1);
        send_packet($urandom_range(1, WML), -1, 0);
        idle(6);
        check("ready_both_full", 32'(ready), 0);
        read_slot("data_a");
        release_slot();
        check("ready_after_rel", 32'(ready), 1);
        check("slot_b_valid", 32'(slot_valid), 1);
        read_slot("data_b");
        release_slot();
        check("slots_empty", 32'(slot_valid), 0);

        // randomized traffic: init bytes, single and double-buffered packets
        for (int it = 0; it < 20; it++) begin
            k = (it == 0) ? 1 : (it == 1) ? WML : $urandom_range(1, WML);
            wait_ready("rdy_rand");
            d  = $urandom_range(0, 31);
            c0 = init_cnt;
            write_byte({5'(d), 3'b001}, 1'b1);
            idle(3);
            check("init_cnt_rand", 32'(init_cnt - c0), 1);
            check("init_data_rand", 32'(init_data), 32'(d));
            send_packet(k, -1, 0);
            wait_slot("slot_rand");
            check("err_rand", 32'(err), 0);
            if ($urandom_range(0, 1) == 1) begin
                wait_ready("rdy_second");
                send_packet($urandom_range(1, WML), -1, 0);
                idle(6);
                read_slot("data_rand1");
                release_slot();
                check("second_valid", 32'(slot_valid), 1);
            end
            read_slot("data_rand");
            release_slot();
        end
        check("rand_drained", 32'(slot_valid), 0);

        // stall the parser behind two full slots and overflow the FIFO
        send_packet($urandom_range(1, WML), -1, 0);
        wait_slot("slot_s1");
        send_packet($urandom_range(1, WML), -1, 0);
        idle(6);
        check("ready_stall", 32'(ready), 0);
        for (int w = 1; w <= 17; w++) begin
            write_byte((w == 1) ? 8'h00 : 8'($urandom_range(0, 255)), w == 1);
            if (w == 11) check("afull_at_11", 32'(afull), 0);
            if (w == 12) check("afull_at_12", 32'(afull), 1);
            if (w == 16) check("err_at_16", 32'(err), 0);
            if (w == 17) check("err_at_17", 32'(err), 1);
        end
        read_slot("data_s1");
        do_reset("rst_ovf");

        // early end at index 43 for key_len=8, then a good packet
        send_packet(8, 43, 0);
        idle(6);
        check("err_early", 32'(err), 1);
        check("slot_early", 32'(slot_valid), 0);
        check("ready_early", 32'(ready), 1);
        send_packet($urandom_range(1, WML), -1, 0);
        wait_slot("slot_after_early");
        read_slot("data_after_early");
        release_slot();

        // key_len 0 and key_len above the maximum
        do_reset("rst_k0");
        send_packet(0, -1, 0);
        idle(6);
        check("err_k0", 32'(err), 1);
        check("slot_k0", 32'(slot_valid), 0);
        send_packet($urandom_range(1, WML), -1, 0);
        wait_slot("slot_after_k0");
        read_slot("data_after_k0");
        release_slot();
        do_reset("rst_kmax");
        send_packet(WML + 1, -1, 0);
        idle(6);
        check("err_kmax", 32'(err), 1);
        check("slot_kmax", 32'(slot_valid), 0);

        // data byte without a header while idle
        do_reset("rst_stray");
        write_byte(8'h5A, 1'b0);
        idle(3);
        check("err_stray", 32'(err), 1);

        // reset in the middle of a packet at index 20
        do_reset("rst_pre_mid");
        write_byte(8'h00, 1'b1);
        for (int i = 1; i <= 20; i++) write_byte(8'($urandom_range(0, 255)), 1'b0);
        idle(3);
        check("mid_ready_low", 32'(ready), 0);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset_vals("rst_mid");
        RST_N = 1'b1;
        idle(3);
        check("mid_no_commit", 32'(slot_valid), 0);
        send_packet($urandom_range(1, WML), -1, 0);
        wait_slot("slot_after_mid");
        read_slot("data_after_mid");
        release_slot();
        check("err_after_mid", 32'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unit_input_rx.md
UNIT_INPUT_RX -- requirements
Module: unit_input_rx

Interface
REQ-001 SHALL have parameter WORD_MAX_LEN, default 64, meaning maximum key length in bytes (multiple of 4, at most 88).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning input byte FIFO depth (power of 2).
REQ-003 SHALL have parameter AFULL_MARGIN, default 4, meaning free FIFO entries at which afull asserts.
REQ-004 SHALL have port CLK  in  1  single clock for all logic.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in  in  8  byte from tx arbiter (broadcast bus).
REQ-007 SHALL have port in_ctrl  in  1  marks header byte or last byte.
REQ-008 SHALL have port wr_en  in  1  byte write strobe for this unit.
REQ-009 SHALL have port afull  out  1  FIFO almost full.
REQ-010 SHALL have port ready  out  1  unit can accept a new data packet.
REQ-011 SHALL have port init_data  out  5  payload of init packet.
REQ-012 SHALL have port init_valid  out  1  one-cycle strobe, init_data valid.
REQ-013 SHALL have port slot_valid  out  1  read slot holds a complete packet.
REQ-014 SHALL have port key_len  out  7  key length of the read slot.
REQ-015 SHALL have port rd_addr  in  5  word address within the read slot.
REQ-016 SHALL have port dout  out  32  word read from the read slot (LE).
REQ-017 SHALL have port slot_release  in  1  core done with the read slot.
REQ-018 SHALL have port err  out  1  sticky protocol error.

Function
REQ-019 SHALL write in/in_ctrl into the byte FIFO on every wr_en cycle; wr_en while full SHALL drop the byte and set err.
REQ-020 SHALL assert afull (registered) when FIFO occupancy >= FIFO_DEPTH-AFULL_MARGIN.
REQ-021 SHALL pop at most one byte per cycle into the parser FSM with states IDLE, DATA, DROP.
REQ-022 IDLE: ctrl=1 and byte[2:0]=3'b001 -> init_data=byte[7:3] and init_valid pulse the next cycle; stays IDLE; back-to-back init bytes each pulse.
REQ-023 IDLE: ctrl=1 and byte=8'h00 -> DATA, byte index=0; ctrl=0 or any other header -> set err and discard.
REQ-024 DATA: SHALL pack bytes little-endian into 32-bit words and write each complete word to word address index/4 of the write slot.
REQ-025 SHALL capture byte index 32 as key_len; 0 or >WORD_MAX_LEN -> set err, go DROP.
REQ-026 Packet end is the byte with ctrl=1; its index SHALL equal 40+ceil4(key_len)-1, else set err and DROP the packet (slot not committed).
REQ-027 Correct end SHALL commit the slot (mark full, store key_len), toggle the write pointer, and return to IDLE.
REQ-028 DROP: SHALL discard bytes until and including the next ctrl=1 byte, then IDLE.
REQ-029 Byte reaching index 127 without ctrl SHALL set err and go DROP.
REQ-030 SHALL have two 32x32 slots, double-buffered; write and read pointers SHALL each toggle.
REQ-031 dout SHALL be registered: 1-cycle latency from rd_addr, from slot at read pointer.
REQ-032 slot_release while slot_valid SHALL clear that slot and toggle read pointer; when ~slot_valid it SHALL be ignored.
REQ-033 SHALL set in_flight on input-side write of a data header (wr_en, in_ctrl, in=0) and clear it on commit or drop end.
REQ-034 ready SHALL be registered: ~in_flight and at least one free slot, and SHALL drop within 1 cycle after a data header write.
REQ-035 Commit and slot_release in the same cycle SHALL both take effect; free-slot count unchanged.

Reset
REQ-036 RST_N low SHALL clear FIFO, pointers, slot flags, in_flight, err, init_valid, FSM to IDLE; afull=0, ready=1, slot_valid=0, dout=0, key_len=0, init_data=0.
REQ-037 Reset mid-packet SHALL discard the partial packet; no slot commit.

Verification
REQ-038 Data packet with key_len=5 (48 bytes, last ctrl=1) -> slot_valid=1, key_len=5, word 8 = 32'h00000005, ready=1.
REQ-039 Header 8'h41 with ctrl=1, two consecutive cycles -> init_valid two pulses, init_data=5'd8, no slot change.
REQ-040 Two packets without release -> ready=0 after second header; release -> ready=1 after one cycle.
REQ-041 key_len=8 packet with ctrl early at index 43 -> err=1, slot_valid=0, next good packet committed.
REQ-042 Burst 16 bytes with no pops possible (parser stalled) -> afull=1 at occupancy 12; 17th write -> err=1.
REQ-043 RST_N low during DATA at index 20 -> all outputs to reset values; subsequent packet parses correctly.
